// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: counter width,
// saturation value and the duty/period value type.
package pwm_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int MAX_DEF   = (1 << CNT_W_DEF) - 1;

  typedef logic [CNT_W_DEF-1:0] pwm_val_t;

  function automatic int max_of(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus a delay flop for an asynchronous PWM input;
// provides synchronized level and single-cycle rise/fall pulses.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic level
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
  assign level = s2;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time in clk cycles, strobes valid_o
// per measurement, and reports a stuck waveform once after a timeout.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             level_o
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(max_of(CNT_W));

  logic             rise, fall, level;
  logic [CNT_W-1:0] cnt, hi;
  logic             armed;

  pwm_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

  assign level_o = level;

  // Measurement stage: synchronizer delay is identical for both edges, so
  // counts taken here equal the transmitted duty/period exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      hi       <= '0;
      armed    <= 1'b0;
      duty_o   <= '0;
      period_o <= '0;
      valid_o  <= 1'b0;
      stuck_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;

      if (rise)
        cnt <= CNT_W'(1);
      else if (cnt != MAX)
        cnt <= cnt + CNT_W'(1);

      if (fall)
        hi <= cnt;

      // A rise coinciding with saturation wins, so a period of MAX is a
      // normal measurement rather than a timeout.
      if (rise) begin
        if (armed) begin
          period_o <= cnt;
          duty_o   <= hi;
          valid_o  <= 1'b1;
        end
        armed   <= 1'b1;
        stuck_o <= 1'b0;
      end else if (cnt == MAX && !stuck_o) begin
        stuck_o  <= 1'b1;
        valid_o  <= 1'b1;
        period_o <= '0;
        duty_o   <= level ? MAX : '0;
        armed    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a cycle-exact PWM stimulus drives pwm_in
// and every valid_o event is compared against hand-computed values.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] duty_o, period_o;
  logic       valid_o, stuck_o, level_o;

  pwm_capture #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .duty_o   (duty_o),
    .period_o (period_o),
    .valid_o  (valid_o),
    .stuck_o  (stuck_o),
    .level_o  (level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int duty;
    int period;
    int stuck;
    int level;
  } ev_t;

  ev_t ev_q[$];
  int  rise_q[$];
  int  cyc = 0;
  int  b2b = 0;
  bit  prev_v = 1'b0;
  int  n_chk = 0;
  int  n_err = 0;
  int  last_r;

  always @(posedge clk) begin
    ev_t e;
    cyc++;
    #1;
    if (valid_o) begin
      e.cyc = cyc; e.duty = int'(duty_o); e.period = int'(period_o);
      e.stuck = int'(stuck_o); e.level = int'(level_o);
      ev_q.push_back(e);
      if (prev_v) b2b++;
    end
    prev_v = valid_o;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic exp_ev(input string tag, input int i, input int d, input int p,
                        input int s, input int l);
    if (i >= ev_q.size()) begin
      check({tag, "_present"}, 0, 1);
      return;
    end
    check({tag, "_duty"},   ev_q[i].duty,   d);
    check({tag, "_period"}, ev_q[i].period, p);
    check({tag, "_stuck"},  ev_q[i].stuck,  s);
    check({tag, "_level"},  ev_q[i].level,  l);
  endtask

  // Drives n cycles of a PWM with high time d and period p, starting at phase 0.
  task automatic gen(input int d, input int p, input int n);
    int ph = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ph == 0 && d > 0 && pwm_in == 1'b0) rise_q.push_back(cyc);
      pwm_in = (ph < d);
      ph = (ph + 1 == p) ? 0 : ph + 1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_duty"},   int'(duty_o),   0);
    check({tag, "_period"}, int'(period_o), 0);
    check({tag, "_valid"},  int'(valid_o),  0);
    check({tag, "_stuck"},  int'(stuck_o),  0);
    check({tag, "_level"},  int'(level_o),  0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // duty 64 / period 200: first rise only arms
    ev_q.delete(); rise_q.delete();
    gen(64, 200, 800);
    check("a_count", ev_q.size(), 3);
    for (int i = 0; i < 3; i++) exp_ev($sformatf("a%0d", i), i, 64, 200, 0, 1);
    if (ev_q.size() > 0 && rise_q.size() > 1)
      check("a_latency", ev_q[0].cyc, rise_q[1] + 3);
    if (ev_q.size() > 1)
      check("a_spacing", ev_q[1].cyc - ev_q[0].cyc, 200);

    // duty 254 / period 255: first report spans the previous 200-cycle period
    ev_q.delete();
    gen(254, 255, 765);
    check("b_count", ev_q.size(), 3);
    exp_ev("b0", 0, 64, 200, 0, 1);
    exp_ev("b1", 1, 254, 255, 0, 1);
    exp_ev("b2", 2, 254, 255, 0, 1);

    // period switch 50 -> 120 mid-period: spanning edge distance is 30
    ev_q.delete();
    gen(10, 50, 130);
    gen(10, 120, 360);
    check("c_count", ev_q.size(), 6);
    exp_ev("c0", 0, 254, 255, 0, 1);
    exp_ev("c1", 1, 10, 50, 0, 1);
    exp_ev("c2", 2, 10, 50, 0, 1);
    exp_ev("c3", 3, 10, 30, 0, 1);
    exp_ev("c4", 4, 10, 120, 0, 1);
    exp_ev("c5", 5, 10, 120, 0, 1);

    // constant low: single stuck report 258 cycles after the last rise drive
    ev_q.delete();
    last_r = rise_q[$];
    gen(0, 100, 300);
    check("d_count", ev_q.size(), 1);
    exp_ev("d0", 0, 0, 0, 1, 0);
    if (ev_q.size() > 0) check("d_time", ev_q[0].cyc, last_r + 258);
    check("d_stuck_hold", int'(stuck_o), 1);

    // constant high: rise only clears/arms, then a stuck report with duty MAX
    ev_q.delete();
    gen(255, 100, 400);
    last_r = rise_q[$];
    check("e_count", ev_q.size(), 1);
    exp_ev("e0", 0, 255, 0, 1, 1);
    if (ev_q.size() > 0) check("e_time", ev_q[0].cyc, last_r + 258);

    // resume pulsing: first rise re-arms silently, next rise reports
    ev_q.delete();
    gen(20, 100, 300);
    check("f_count", ev_q.size(), 1);
    exp_ev("f0", 0, 20, 100, 0, 1);
    check("f_stuck_clear", int'(stuck_o), 0);

    // reset mid-period
    gen(30, 80, 100);
    @(negedge clk);
    rst_n = 1'b0;
    pwm_in = 1'b0;
    #1 check_zero("g_rst");
    repeat (3) @(negedge clk);
    ev_q.delete(); rise_q.delete();
    rst_n = 1'b1;
    gen(30, 80, 320);
    check("g_count", ev_q.size(), 3);
    for (int i = 0; i < 3; i++) exp_ev($sformatf("g%0d", i), i, 30, 80, 0, 1);
    if (ev_q.size() > 0 && rise_q.size() > 1)
      check("g_first", ev_q[0].cyc, rise_q[1] + 3);

    check("b2b_valid", b2b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
